systolic_array_4x4: RTL and testbench
=====================================

Name: systolic_array_4x4

Overview:
- Output-stationary 4x4 signed integer systolic array computing C = A x B by streaming operands.
- Row operands enter from the left (a1..a4, one per row) and column operands enter from the top (b1..b4, one per column).
- Each of 16 processing elements (PEs) multiplies its two operands, accumulates into its own register, and forwards a rightward and b downward.
- Used as the matrix-multiply core of the GPU datapath; the upstream feeder applies the diagonal skew.

Parameters:
- DATA_W, 8, width of signed a/b operands.
- ACC_W, 32, width of signed per-PE accumulators and c outputs.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- a1..a4  in  DATA_W (signed)  row operand streams; ai feeds row i.
- b1..b4  in  DATA_W (signed)  column operand streams; bj feeds column j.
- c11..c44  out  ACC_W (signed)  accumulator of PE(i,j), driven directly from its register.

Behaviour:
- One clock; reset is synchronous and active-high.
- PE(i,j) inputs:
  - a_in = ai when j=1, else the a_reg of PE(i,j-1).
  - b_in = bj when i=1, else the b_reg of PE(i-1,j).
- Each rising edge with rst=0, every PE updates:
  - a_reg <= a_in
  - b_reg <= b_in
  - acc <= acc + sext(a_in*b_in)
- Arithmetic:
  - The product is a full signed DATA_W x DATA_W multiply (2*DATA_W bits).
  - It is sign-extended to ACC_W before the add.
  - The accumulator wraps modulo 2^ACC_W; there is no saturation and no overflow flag.
- Reset: on a rising edge with rst=1, all acc, a_reg and b_reg clear to 0, so every c output reads 0 after that edge. Reset has priority over accumulation. Asserting reset mid-computation discards all partial sums and in-flight operands.
- No clear other than rst; results persist and keep accumulating.
  - Zero operands add nothing, so after the last operands drain, outputs hold.
  - Nonzero operands keep adding to existing sums; the caller must reset between matrix products.
- Timing:
  - An operand applied to ai before edge t reaches PE(i,j)'s input j-1 edges later.
  - bj behaves the same way, taking i-1 edges to reach row i.
  - PE(i,j) adds that product at the edge where both operands are present.
  - c(i,j) reflects a product one edge after the operands reach the PE inputs.
- Skew contract (caller's duty):
  - Element k (k=0..3) of row i goes on ai at cycle T+k+(i-1).
  - Element k of column j goes on bj at cycle T+k+(j-1).
  - Inputs are 0 outside these windows.
  - PE(i,j) then sees pair k at cycle T+k+(i-1)+(j-1).
- Completion: the final product lands in c44 at the edge closing cycle T+3+6, i.e. 10 cycles after T. c11 finalises at the edge closing cycle T+3.
- No handshakes, valid signals or state machine; the array is purely registered and data-driven.
- Operands flowing off the right/bottom edges are dropped.

Test Plan:
- Reset: drive nonzero inputs, assert rst for 1 edge -> all c = 0. Hold rst with nonzero inputs -> outputs remain 0.
- Skewed product: T=1 with a1 stream 1,2,3,4, a2 2,3,4,5, a3 3..6, a4 4..7, b1 5..8, b2 6..9, b3 7..10, b4 8..11, each stream offset by its index, then zeros for 10+ cycles -> results:
  - row 1: 70 80 90 100
  - row 2: 96 110 124 138
  - row 3: 122 140 158 176
  - row 4: 148 170 192 214
- Hold: after the above, run 20 more cycles of zero inputs -> outputs unchanged.
- Signed: single pair a1=-128, b1=-128 at one cycle -> c11=16384. Then a1=-3, b1=7 -> c11=16363. All other c stay 0 (a reaches PE12 but b2=0).
- Propagation timing: a1=2, b1=3 for one cycle only -> c11=6 one edge later. c12..c14 and c21..c41 stay 0 because the partner operands are 0.
- Mid-run reset: assert rst during the cycle-4 feed of the skewed-product test -> all c=0. Restart the full sequence after reset -> same 16 results as the skewed-product case.

Source files
------------

// File: rtl/systolic_array_4x4.sv
// Output-stationary 4x4 signed systolic array: a flows right, b flows down,
// and every PE accumulates a*b into its own register (wraps modulo 2^ACC_W).
module systolic_array_4x4 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a1,
    input  logic signed [DATA_W-1:0] a2,
    input  logic signed [DATA_W-1:0] a3,
    input  logic signed [DATA_W-1:0] a4,
    input  logic signed [DATA_W-1:0] b1,
    input  logic signed [DATA_W-1:0] b2,
    input  logic signed [DATA_W-1:0] b3,
    input  logic signed [DATA_W-1:0] b4,
    output logic signed [ACC_W-1:0]  c11,
    output logic signed [ACC_W-1:0]  c12,
    output logic signed [ACC_W-1:0]  c13,
    output logic signed [ACC_W-1:0]  c14,
    output logic signed [ACC_W-1:0]  c21,
    output logic signed [ACC_W-1:0]  c22,
    output logic signed [ACC_W-1:0]  c23,
    output logic signed [ACC_W-1:0]  c24,
    output logic signed [ACC_W-1:0]  c31,
    output logic signed [ACC_W-1:0]  c32,
    output logic signed [ACC_W-1:0]  c33,
    output logic signed [ACC_W-1:0]  c34,
    output logic signed [ACC_W-1:0]  c41,
    output logic signed [ACC_W-1:0]  c42,
    output logic signed [ACC_W-1:0]  c43,
    output logic signed [ACC_W-1:0]  c44
);

    logic signed [DATA_W-1:0]   a_row [4];
    logic signed [DATA_W-1:0]   b_col [4];
    logic signed [DATA_W-1:0]   a_in  [4][4];
    logic signed [DATA_W-1:0]   b_in  [4][4];
    logic signed [DATA_W-1:0]   a_q   [4][4];
    logic signed [DATA_W-1:0]   b_q   [4][4];
    logic signed [2*DATA_W-1:0] prod  [4][4];
    logic signed [ACC_W-1:0]    acc_d [4][4];
    logic signed [ACC_W-1:0]    acc_q [4][4];

    assign a_row[0] = a1;
    assign a_row[1] = a2;
    assign a_row[2] = a3;
    assign a_row[3] = a4;
    assign b_col[0] = b1;
    assign b_col[1] = b2;
    assign b_col[2] = b3;
    assign b_col[3] = b4;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_in[i][0] = a_row[i];
            b_in[0][i] = b_col[i];
            for (int j = 1; j < 4; j++) begin
                a_in[i][j] = a_q[i][j-1];
                b_in[j][i] = b_q[j-1][i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                // Full-width signed product, sign-extended into the accumulator.
                prod[i][j]  = (2*DATA_W)'(a_in[i][j]) * (2*DATA_W)'(b_in[i][j]);
                acc_d[i][j] = acc_q[i][j] + ACC_W'(prod[i][j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (rst) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                end else begin
                    a_q[i][j]   <= a_in[i][j];
                    b_q[i][j]   <= b_in[i][j];
                    acc_q[i][j] <= acc_d[i][j];
                end
            end
        end
    end

    assign c11 = acc_q[0][0];
    assign c12 = acc_q[0][1];
    assign c13 = acc_q[0][2];
    assign c14 = acc_q[0][3];
    assign c21 = acc_q[1][0];
    assign c22 = acc_q[1][1];
    assign c23 = acc_q[1][2];
    assign c24 = acc_q[1][3];
    assign c31 = acc_q[2][0];
    assign c32 = acc_q[2][1];
    assign c33 = acc_q[2][2];
    assign c34 = acc_q[2][3];
    assign c41 = acc_q[3][0];
    assign c42 = acc_q[3][1];
    assign c43 = acc_q[3][2];
    assign c44 = acc_q[3][3];

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Bench for systolic_array_4x4: skewed-matrix vector table, corner sequences,
// and random streams checked against an input-history reference model.
module tb_systolic_array_4x4;

    typedef logic [3:0][7:0] vec4_t;

    typedef struct {
        bit                rst;
        vec4_t             a;
        vec4_t             b;
        bit                chk;
        logic [15:0][31:0] exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [7:0]   a_drv [4];
    logic signed [7:0]   b_drv [4];
    logic signed [31:0]  c_dut [16];

    int checks = 0;
    int errors = 0;

    // Reference state: operand history since the last reset and the running sums.
    vec4_t ha [$];
    vec4_t hb [$];
    int    macc [16];

    vec_t tbl [14];
    int   exp_c [16] = '{70, 80, 90, 100, 96, 110, 124, 138,
                         122, 140, 158, 176, 148, 170, 192, 214};

    always #5 clk = ~clk;

    systolic_array_4x4 #(.DATA_W(8), .ACC_W(32)) dut (
        .clk(clk), .rst(rst),
        .a1(a_drv[0]), .a2(a_drv[1]), .a3(a_drv[2]), .a4(a_drv[3]),
        .b1(b_drv[0]), .b2(b_drv[1]), .b3(b_drv[2]), .b4(b_drv[3]),
        .c11(c_dut[0]),  .c12(c_dut[1]),  .c13(c_dut[2]),  .c14(c_dut[3]),
        .c21(c_dut[4]),  .c22(c_dut[5]),  .c23(c_dut[6]),  .c24(c_dut[7]),
        .c31(c_dut[8]),  .c32(c_dut[9]),  .c33(c_dut[10]), .c34(c_dut[11]),
        .c41(c_dut[12]), .c42(c_dut[13]), .c43(c_dut[14]), .c44(c_dut[15])
    );

    task automatic chk(input string nm, input logic signed [31:0] act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_all_const(input string tag, input int expv [16]);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s_c%0d%0d", tag, k / 4 + 1, k % 4 + 1), c_dut[k], expv[k]);
    endtask

    // PE(i,j) at cycle n sees a_i from cycle n-j and b_j from cycle n-i.
    task automatic model_edge(input bit r, input vec4_t a, input vec4_t b);
        int    n, sa, sb;
        vec4_t va, vb;
        if (r) begin
            ha.delete();
            hb.delete();
            for (int k = 0; k < 16; k++) macc[k] = 0;
        end else begin
            ha.push_back(a);
            hb.push_back(b);
            n = ha.size() - 1;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    sa = n - j;
                    sb = n - i;
                    if (sa >= 0 && sb >= 0) begin
                        va = ha[sa];
                        vb = hb[sb];
                        macc[i*4+j] += int'($signed(va[i])) * int'($signed(vb[j]));
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input vec4_t a, input vec4_t b);
        rst = r;
        for (int k = 0; k < 4; k++) begin
            a_drv[k] = a[k];
            b_drv[k] = b[k];
        end
        @(posedge clk);
        #1;
        model_edge(r, a, b);
        for (int k = 0; k < 16; k++)
            chk($sformatf("model_c%0d%0d", k / 4 + 1, k % 4 + 1), c_dut[k], macc[k]);
    endtask

    task automatic run_table(input int last, input bit do_chk);
        for (int c = 0; c <= last; c++) begin
            step(tbl[c].rst, tbl[c].a, tbl[c].b);
            if (do_chk && tbl[c].chk)
                for (int k = 0; k < 16; k++)
                    chk($sformatf("skew%0d_c%0d%0d", c, k / 4 + 1, k % 4 + 1),
                        c_dut[k], int'(tbl[c].exp[k]));
        end
    endtask

    initial begin
        vec4_t z, nz, va, vb;
        int    zeros [16];
        int    kk;
        z  = '0;
        nz = {8'sd9, -8'sd4, 8'sd17, 8'sd100};
        for (int k = 0; k < 16; k++) zeros[k] = 0;
        for (int k = 0; k < 4; k++) begin
            a_drv[k] = '0;
            b_drv[k] = '0;
        end

        // Skewed product vectors: element k of row/column i on cycle k+i.
        for (int c = 0; c < 14; c++) begin
            tbl[c].rst = 1'b0;
            tbl[c].a   = '0;
            tbl[c].b   = '0;
            for (int i = 0; i < 4; i++) begin
                kk = c - i;
                if (kk >= 0 && kk <= 3) begin
                    tbl[c].a[i] = 8'(i + 1 + kk);
                    tbl[c].b[i] = 8'(5 + i + kk);
                end
            end
            tbl[c].chk = (c >= 9);
            for (int k = 0; k < 16; k++) tbl[c].exp[k] = 32'(exp_c[k]);
        end

        // Reset with nonzero inputs, single edge then held.
        step(1'b1, nz, nz);
        chk_all_const("rst1", zeros);
        for (int n = 0; n < 3; n++) step(1'b1, nz, nz);
        chk_all_const("rsthold", zeros);

        // Skewed product; completes at the edge closing cycle T+9.
        run_table(13, 1'b1);

        for (int n = 0; n < 20; n++) step(1'b0, z, z);
        chk_all_const("hold", exp_c);

        // Mid-run reset during the cycle-4 feed, then a full restart.
        step(1'b1, z, z);
        run_table(3, 1'b0);
        step(1'b1, tbl[4].a, tbl[4].b);
        chk_all_const("midrst", zeros);
        run_table(13, 1'b1);

        // Signed extremes on PE(1,1).
        step(1'b1, z, z);
        va = '0; vb = '0;
        va[0] = 8'h80; vb[0] = 8'h80;
        step(1'b0, va, vb);
        chk("signed_c11_a", c_dut[0], 16384);
        va[0] = 8'hFD; vb[0] = 8'd7;
        step(1'b0, va, vb);
        chk("signed_c11_b", c_dut[0], 16363);
        for (int n = 0; n < 6; n++) step(1'b0, z, z);
        for (int k = 1; k < 16; k++)
            chk($sformatf("signed_other_c%0d%0d", k / 4 + 1, k % 4 + 1), c_dut[k], 0);
        chk("signed_c11_hold", c_dut[0], 16363);

        // Single-cycle pair: visible in c11 one edge later, nowhere else.
        step(1'b1, z, z);
        va = '0; vb = '0;
        va[0] = 8'd2; vb[0] = 8'd3;
        step(1'b0, va, vb);
        chk("prop_c11", c_dut[0], 6);
        for (int n = 0; n < 5; n++) step(1'b0, z, z);
        chk("prop_c11_hold", c_dut[0], 6);
        for (int k = 1; k < 16; k++)
            chk($sformatf("prop_c%0d%0d", k / 4 + 1, k % 4 + 1), c_dut[k], 0);

        // Random full-range streams with occasional resets.
        step(1'b1, z, z);
        for (int n = 0; n < 300; n++) begin
            va = vec4_t'({$urandom, $urandom});
            vb = vec4_t'({$urandom, $urandom});
            step(($urandom_range(0, 63) == 0), va, vb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
